// File: rtl/mem_access_unit.sv
// Load/store initiator between the MEM stage and Data_Memory: one byte/half/word
// request at a time, read-modify-write for sub-word stores, extended load data.
module mem_access_unit #(
  parameter logic [31:0] BASE_ADDR   = 32'h00000080,
  parameter int          DEPTH_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_writeData,
  output logic        mem_memRead,
  output logic        mem_memWrite,
  input  logic [31:0] mem_readData
);

  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);

  typedef enum logic [2:0] {IDLE, LOAD, STW, RMW_RD, RMW_WR, RESP} state_t;

  state_t      state, state_n;
  logic [1:0]  size_p0;
  logic        sgn_p0;
  logic [1:0]  lane_p0;
  logic [15:0] wdata_p0;

  function automatic logic acc_err(input logic [1:0] size, input logic [31:0] addr);
    logic [32:0] a;
    a = {1'b0, addr};
    acc_err = (size == 2'b11) ||
              (size == 2'b01 && addr[0]) ||
              (size == 2'b10 && addr[1:0] != 2'b00) ||
              (a < {1'b0, BASE_ADDR}) || (a >= END_ADDR);
  endfunction

  function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic sgn, input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   lane_extract = {{24{sgn & b[7]}}, b};
      2'b01:   lane_extract = {{16{sgn & h[15]}}, h};
      default: lane_extract = word;
    endcase
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [15:0] wd,
                                             input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] r;
    r = old;
    if (size == 2'b00) begin
      case (lane)
        2'd0:    r[7:0]   = wd[7:0];
        2'd1:    r[15:8]  = wd[7:0];
        2'd2:    r[23:16] = wd[7:0];
        default: r[31:24] = wd[7:0];
      endcase
    end else if (lane[1]) begin
      r[31:16] = wd;
    end else begin
      r[15:0] = wd;
    end
    lane_merge = r;
  endfunction

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (acc_err(req_size, req_addr)) state_n = RESP;
          else if (!req_write)             state_n = LOAD;
          else if (req_size == 2'b10)      state_n = STW;
          else                             state_n = RMW_RD;
        end
      end
      LOAD, STW, RMW_WR: state_n = RESP;
      RMW_RD:            state_n = RMW_WR;
      RESP:              state_n = IDLE;
      default:           state_n = IDLE;
    endcase
  end

  // p0: request fields captured at the acceptance edge
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) begin
      size_p0  <= req_size;
      sgn_p0   <= req_signed;
      lane_p0  <= req_addr[1:0];
      wdata_p0 <= req_wdata[15:0];
    end
  end

  // Outputs registered from the next state; a write strobe high at a reset edge still commits
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_err      <= 1'b0;
      resp_rdata    <= 32'h0;
      mem_memRead   <= 1'b0;
      mem_memWrite  <= 1'b0;
      mem_addr      <= 32'h0;
      mem_writeData <= 32'h0;
    end else begin
      state        <= state_n;
      req_ready    <= (state_n == IDLE);
      resp_valid   <= (state_n == RESP);
      mem_memRead  <= (state_n == LOAD) || (state_n == RMW_RD);
      mem_memWrite <= (state_n == STW) || (state_n == RMW_WR);
      // Only a rejected request goes straight from IDLE to RESP
      resp_err     <= (state_n == RESP) && (state == IDLE);
      if (state_n == RESP)
        resp_rdata <= (state == LOAD) ? lane_extract(mem_readData, size_p0, sgn_p0, lane_p0) : 32'h0;
      if (state == IDLE && state_n != RESP && state_n != IDLE)
        mem_addr <= {req_addr[31:2], 2'b00};
      if (state_n == STW)
        mem_writeData <= req_wdata;
      else if (state_n == RMW_WR)
        mem_writeData <= lane_merge(mem_readData, wdata_p0, size_p0, lane_p0);
    end
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store initiator that sits between the MIPS datapath (MEM stage) and Data_Memory.
- Accepts one byte, halfword or word request at a time through a valid/ready handshake.
- Drives Data_Memory's addr/writeData/memRead/memWrite strobes, and performs read-modify-write for sub-word stores.
- Returns aligned, sign- or zero-extended load data with a one-cycle response pulse; flags misaligned and out-of-range accesses.

Parameters:
- BASE_ADDR, 32'h00000080, byte address of memory word 0.
- DEPTH_WORDS, 32, number of 32-bit words behind BASE_ADDR.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit idle, can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-justified.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_err  output  1  valid with resp_valid; misaligned, out-of-range or illegal size.
- mem_addr  output  32  word-aligned byte address to Data_Memory (addr[1:0] = 00).
- mem_writeData  output  32  write word to Data_Memory.
- mem_memRead  output  1  read strobe.
- mem_memWrite  output  1  write strobe, committed by Data_Memory on the rising edge.
- mem_readData  input  32  combinational read data from Data_Memory.

Behaviour:
- All outputs are registered.
- Reset (rst high at an edge):
  - state goes to IDLE.
  - req_ready = 1.
  - resp_valid, resp_err, mem_memRead and mem_memWrite = 0.
  - resp_rdata, mem_addr and mem_writeData = 0.
- States:
  - IDLE: req_ready = 1. A request is accepted when req_valid & req_ready at an edge. All request fields are captured and req_ready drops the next cycle.
  - Acceptance checks, in priority order: size 11; half with addr[0] != 0; word with addr[1:0] != 0; addr < BASE_ADDR or addr >= BASE_ADDR + 4*DEPTH_WORDS. Any failure -> RESP with err = 1, and no memory strobe is ever asserted.
  - LOAD: mem_memRead = 1, mem_addr = {addr[31:2],2'b00}. mem_readData is captured at the end of the cycle -> RESP.
  - STW (word store): mem_memWrite = 1, mem_writeData = req_wdata -> RESP.
  - RMW_RD (sub-word store): mem_memRead = 1; the old word is captured -> RMW_WR.
  - RMW_WR: mem_memWrite = 1, mem_writeData = old word with the target lane replaced -> RESP.
  - RESP: resp_valid = 1 for exactly one cycle -> IDLE. req_ready returns to 1 in the following cycle, so back-to-back accesses run at one per 3 (load/word store) or 4 (sub-word store) cycles.
- Strobes are low in every state other than those listed above; memRead and memWrite are never high together.
- Byte lanes are little-endian:
  - addr[1:0] = 0 selects bits 7:0 and 3 selects bits 31:24.
  - Half at addr[1] = 0 is bits 15:0; at addr[1] = 1 it is bits 31:16.
  - Store data comes from req_wdata[7:0] or req_wdata[15:0].
- Load extension: req_signed replicates the top bit of the lane; otherwise the upper bits are zero. Word loads ignore req_signed.
- Latency, in cycles after the acceptance edge, until resp_valid is high:
  - error: 1
  - load / word store: 2
  - sub-word store: 3
- req_valid is ignored while req_ready = 0; a held request is not queued.
- Reset mid-operation:
  - A write whose mem_memWrite is already high in the reset cycle still commits, because memory samples the same edge.
  - No further strobe or resp_valid follows.
  - A pending RMW that has not reached RMW_WR is dropped with no memory change.
- resp_rdata holds its value until the next RESP or reset.

Test Plan:
- Reset: hold rst for 2 cycles with req_valid = 1 -> req_ready = 1, all strobes 0, resp_valid 0, and no acceptance during reset.
- Word store then load: mem[0] preloaded 0; sw 0xDEADBEEF @0x80 gives resp_valid 2 cycles after acceptance with err = 0. Then lw @0x80 gives resp_rdata = 0xDEADBEEF; mem_addr = 0x80 on both strobes.
- Sub-word store RMW: mem[1] = 0x11223344; sb 0xAA @0x86 -> memRead cycle, then a memWrite cycle with writeData = 0x11AA3344, resp 3 cycles after acceptance. Then sh 0xBEEF @0x86 -> mem[1] = 0xBEEF3344.
- Load extension: mem[2] = 0x80F17F00. lb signed @0x8B -> 0xFFFFFF80; lbu @0x8B -> 0x00000080; lh signed @0x88 -> 0x00007F00; lh signed @0x8A -> 0xFFFF80F1.
- Errors: lw @0x82, lh @0x81, lw @0x7C, lw @0x100, and size 11 -> each gives resp_err = 1 one cycle after acceptance, resp_rdata = 0, and zero memRead/memWrite pulses.
- Reset during RMW: sb @0x84, assert rst in the RMW_RD cycle -> mem[1] unchanged, no resp_valid, and req_ready = 1 the cycle after reset.
